simt_lane_mem_arbiter: RTL and testbench



---
 rtl/simt_mem_pkg.sv | 15 +
 rtl/bank_conflict_grant.sv | 53 +++++
 rtl/simt_lane_mem_arbiter.sv | 114 +++++++++++
 tb/tb_simt_lane_mem_arbiter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/simt_mem_pkg.sv
// Shared constants, lane types and arbiter state encoding for the SIMT lane memory arbiter.
package simt_mem_pkg;

    localparam int NUM_LANES = 4;
    localparam int BANK_BITS = 2;
    localparam int ADDR_W    = 14;
    localparam int DATA_W    = 32;

    typedef logic [ADDR_W-1:0] lane_addr_t;
    typedef logic [DATA_W-1:0] lane_data_t;
    typedef logic [1:0]        lane_idx_t;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_t;

endpackage

// File: rtl/bank_conflict_grant.sv
// Combinational round grant: lowest pending lane per bank wins; with LANE_ARB_BROADCAST_EN,
// reads matching a lower granted read's address ride along on that lane's read data.
module bank_conflict_grant #(
    parameter int ADDR_W = simt_mem_pkg::ADDR_W
) (
    input  logic [3:0]             pending,
    input  logic [3:0][ADDR_W-1:0] addr,
    input  logic [3:0]             we,
    output logic [3:0]             grant
`ifdef LANE_ARB_BROADCAST_EN
    ,
    output logic [3:0]             bcast,
    output logic [3:0][1:0]        src
`endif
);
    import simt_mem_pkg::*;

    logic [(1<<BANK_BITS)-1:0] bank_used;
    logic [3:0]                hit;

    always_comb begin
        grant     = '0;
        bank_used = '0;
        hit       = '0;
`ifdef LANE_ARB_BROADCAST_EN
        src = {2'd3, 2'd2, 2'd1, 2'd0};
`endif
        for (int j = 0; j < NUM_LANES; j++) begin
            if (pending[j]) begin
`ifdef LANE_ARB_BROADCAST_EN
                for (int i = 0; i < NUM_LANES; i++) begin
                    if (i < j && !hit[j] && grant[i] && !we[i] && !we[j] && addr[i] == addr[j]) begin
                        hit[j] = 1'b1;
                        src[j] = lane_idx_t'(i);
                    end
                end
`endif
                if (!hit[j] && !bank_used[addr[j][BANK_BITS-1:0]]) begin
                    grant[j] = 1'b1;
                    bank_used[addr[j][BANK_BITS-1:0]] = 1'b1;
                end
            end
        end
    end

`ifdef LANE_ARB_BROADCAST_EN
    assign bcast = hit;
`else
    logic unused_addr_bits;
    assign unused_addr_bits = ^addr;
`endif

endmodule

// File: rtl/simt_lane_mem_arbiter.sv
// Warp-wide request serializer in front of the 4-port banked SRAM; issues bank-disjoint lane sets
// per round and gathers read data into one response. Optional feature macro: LANE_ARB_BROADCAST_EN.
module simt_lane_mem_arbiter #(
    parameter int ADDR_W = simt_mem_pkg::ADDR_W,
    parameter int DATA_W = simt_mem_pkg::DATA_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [3:0]             req_mask,
    input  logic [3:0]             req_we,
    input  logic [3:0][ADDR_W-1:0] req_addr,
    input  logic [3:0][DATA_W-1:0] req_wd,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [3:0][DATA_W-1:0] resp_rdata,
    output logic [3:0][ADDR_W-1:0] mem_addr,
    output logic [3:0]             mem_we,
    output logic [3:0][DATA_W-1:0] mem_wd,
    input  logic [3:0][DATA_W-1:0] mem_rd
);
    import simt_mem_pkg::*;

    arb_state_t             state, state_nxt;
    logic [3:0]             pending, lat_we, grant, issue_grant, retire, last_cap;
    logic [3:0][1:0]        src, last_src;
    logic [3:0][ADDR_W-1:0] lat_addr, held_addr;
    logic [3:0][DATA_W-1:0] lat_wd;
    logic                   accept;

    assign accept      = (state == IDLE) && req_valid;
    assign issue_grant = grant & {4{state == ISSUE}};

`ifdef LANE_ARB_BROADCAST_EN
    logic [3:0] bcast;
    bank_conflict_grant #(.ADDR_W(ADDR_W)) u_grant (
        .pending(pending), .addr(lat_addr), .we(lat_we), .grant(grant), .bcast(bcast), .src(src)
    );
    assign retire = issue_grant | (bcast & {4{state == ISSUE}});
`else
    bank_conflict_grant #(.ADDR_W(ADDR_W)) u_grant (
        .pending(pending), .addr(lat_addr), .we(lat_we), .grant(grant)
    );
    assign retire = issue_grant;
    assign src    = {2'd3, 2'd2, 2'd1, 2'd0};
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            // An empty request skips the issue rounds but still takes one cycle to respond.
            IDLE:  if (req_valid) state_nxt = (req_mask == 4'b0) ? WAIT : ISSUE;
            ISSUE: if ((pending & ~retire) == 4'b0) state_nxt = WAIT;
            WAIT:  state_nxt = RESP;
            RESP:  if (resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (state == IDLE);
        resp_valid = (state == RESP);
        for (int i = 0; i < NUM_LANES; i++) begin
            mem_addr[i] = issue_grant[i] ? lat_addr[i] : held_addr[i];
            mem_we[i]   = issue_grant[i] & lat_we[i];
            mem_wd[i]   = issue_grant[i] ? lat_wd[i] : '0;
        end
    end

    // NOTE: request payload registers carry no reset; they are only read after being loaded on accept.
    always_ff @(posedge clk) begin
        if (accept) begin
            lat_addr <= req_addr;
            lat_we   <= req_we;
            lat_wd   <= req_wd;
        end
    end

    // Read data for a round arrives one cycle after its issue edge, so capture lags by one edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending    <= '0;
            last_cap   <= '0;
            last_src   <= '0;
            held_addr  <= '0;
            resp_rdata <= '0;
        end else begin
            if (accept) begin
                pending    <= req_mask;
                last_cap   <= '0;
                resp_rdata <= '0;
            end
            if (state == ISSUE) begin
                pending  <= pending & ~retire;
                last_cap <= retire & ~lat_we;
                last_src <= src;
                for (int i = 0; i < NUM_LANES; i++)
                    if (issue_grant[i]) held_addr[i] <= lat_addr[i];
            end
            if (state == WAIT) last_cap <= '0;
            if (state == ISSUE || state == WAIT) begin
                for (int i = 0; i < NUM_LANES; i++)
                    if (last_cap[i]) resp_rdata[i] <= mem_rd[last_src[i]];
            end
        end
    end

endmodule

// File: tb/tb_simt_lane_mem_arbiter.sv
// Self-checking bench for simt_lane_mem_arbiter: directed table, corner sequences, and random
// requests checked against a flat memory model with per-bank round counting.
module tb_simt_lane_mem_arbiter;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [3:0]        req_mask = '0;
    logic [3:0]        req_we = '0;
    logic [3:0][13:0]  req_addr = '0;
    logic [3:0][31:0]  req_wd = '0;
    logic              resp_valid;
    logic              resp_ready = 1'b0;
    logic [3:0][31:0]  resp_rdata;
    logic [3:0][13:0]  mem_addr;
    logic [3:0]        mem_we;
    logic [3:0][31:0]  mem_wd;
    logic [3:0][31:0]  mem_rd;

    int errors = 0;
    int checks = 0;
    int we_cnt = 0;
    logic mem_init = 1'b1;

    logic [31:0] sram    [0:16383];
    logic [31:0] ref_mem [0:255];

    simt_lane_mem_arbiter dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_mask(req_mask), .req_we(req_we), .req_addr(req_addr), .req_wd(req_wd),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    always #5 clk = ~clk;

    // Four-port SRAM with one-cycle synchronous read.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int a = 0; a < 256; a++) sram[a] <= 32'h1000 + a;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (mem_we[i]) sram[mem_addr[i]] <= mem_wd[i];
                mem_rd[i] <= sram[mem_addr[i]];
            end
        end
    end

    always @(posedge clk) if (|mem_we) we_cnt <= we_cnt + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Rounds needed: per bank, each round removes the lowest pending lane (and, with broadcast,
    // every later read of the same address in that bank).
    function automatic int exp_rounds(input logic [3:0] mask, we, input logic [3:0][13:0] addr);
        int k = 0;
        for (int b = 0; b < 4; b++) begin
            int  r = 0;
            bit  done [4] = '{0, 0, 0, 0};
            for (int i = 0; i < 4; i++) begin
                if (mask[i] && addr[i][1:0] == b && !done[i]) begin
                    r++;
                    done[i] = 1;
`ifdef LANE_ARB_BROADCAST_EN
                    if (!we[i])
                        for (int j = i + 1; j < 4; j++)
                            if (mask[j] && !we[j] && addr[j] == addr[i]) done[j] = 1;
`endif
                end
            end
            if (r > k) k = r;
        end
        return k;
    endfunction

    function automatic logic [3:0][31:0] exp_read(input logic [3:0] mask, we, input logic [3:0][13:0] addr);
        logic [3:0][31:0] r = '0;
        for (int i = 0; i < 4; i++)
            if (mask[i] && !we[i]) r[i] = ref_mem[addr[i][7:0]];
        return r;
    endfunction

    task automatic apply_writes(input logic [3:0] mask, we, input logic [3:0][13:0] addr, input logic [3:0][31:0] wd);
        for (int i = 0; i < 4; i++)
            if (mask[i] && we[i]) ref_mem[addr[i][7:0]] = wd[i];
    endtask

    task automatic drive_req(input logic [3:0] mask, we, input logic [3:0][13:0] addr, input logic [3:0][31:0] wd);
        int guard = 0;
        while (!req_ready && guard < 50) begin @(posedge clk); #1; guard++; end
        check("req_ready_wait", {127'b0, req_ready}, 128'd1);
        req_valid = 1'b1; req_mask = mask; req_we = we; req_addr = addr; req_wd = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_resp(inout int lat);
        while (!resp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    endtask

    task automatic take_resp(output logic [3:0][31:0] rd);
        rd = resp_rdata;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
    endtask

    task automatic do_req(input logic [3:0] mask, we, input logic [3:0][13:0] addr, input logic [3:0][31:0] wd,
                          output logic [3:0][31:0] rd, output int lat);
        drive_req(mask, we, addr, wd);
        lat = 0;
        wait_resp(lat);
        take_resp(rd);
    endtask

    typedef struct {
        logic [3:0]       mask;
        logic [3:0]       we;
        logic [3:0][13:0] addr;
        logic [3:0][31:0] wd;
        logic [3:0][31:0] exp;
        int               lat;
    } vec_t;

`ifdef LANE_ARB_BROADCAST_EN
    localparam int SAME_ADDR_LAT = 2;
`else
    localparam int SAME_ADDR_LAT = 5;
`endif

    initial begin
        vec_t             vecs [7];
        logic [3:0][31:0] rd, snap;
        logic [3:0]       m, w;
        logic [3:0][13:0] a;
        logic [3:0][31:0] d;
        int               lat, w0;

        for (int i = 0; i < 256; i++) ref_mem[i] = 32'h1000 + i;

        vecs[0] = '{4'b1111, 4'b1111, {14'd2, 14'd3, 14'd5, 14'd0}, {32'd5555, 32'd789, 32'd456, 32'd123}, '0, 2};
        vecs[1] = '{4'b1111, 4'b0000, {14'd0, 14'd3, 14'd2, 14'd5}, '0, {32'd123, 32'd789, 32'd5555, 32'd456}, 2};
        vecs[2] = '{4'b1111, 4'b0000, {14'd12, 14'd8, 14'd4, 14'd0}, '0, {32'h100C, 32'h1008, 32'h1004, 32'd123}, 5};
        vecs[3] = '{4'b0101, 4'b0000, {14'd13, 14'd5, 14'd9, 14'd1}, '0, {32'd0, 32'd456, 32'd0, 32'h1001}, 3};
        vecs[4] = '{4'b0001, 4'b0001, {14'd0, 14'd0, 14'd0, 14'd7}, {32'd0, 32'd0, 32'd0, 32'd42}, '0, 2};
        vecs[5] = '{4'b1111, 4'b0000, {14'd7, 14'd7, 14'd7, 14'd7}, '0, {32'd42, 32'd42, 32'd42, 32'd42}, SAME_ADDR_LAT};
        vecs[6] = '{4'b0000, 4'b1111, {14'd3, 14'd2, 14'd1, 14'd0}, {32'd9, 32'd9, 32'd9, 32'd9}, '0, 1};

        @(posedge clk); @(posedge clk); #1;
        mem_init = 1'b0;
        check("reset_req_ready", {127'b0, req_ready}, 128'd1);
        check("reset_resp_valid", {127'b0, resp_valid}, 128'd0);
        check("reset_mem", {mem_we, mem_addr, mem_wd[0]}, 128'd0);
        check("reset_rdata", resp_rdata, 128'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        for (int t = 0; t < 7; t++) begin
            w0 = we_cnt;
            do_req(vecs[t].mask, vecs[t].we, vecs[t].addr, vecs[t].wd, rd, lat);
            check($sformatf("tab%0d_rdata", t), rd, vecs[t].exp);
            check($sformatf("tab%0d_latency", t), lat, vecs[t].lat);
            if ((vecs[t].mask & vecs[t].we) == 4'b0)
                check($sformatf("tab%0d_no_write", t), we_cnt - w0, 128'd0);
            apply_writes(vecs[t].mask, vecs[t].we, vecs[t].addr, vecs[t].wd);
        end

        // Backpressure: response held while a competing request waits.
        a = {14'd0, 14'd3, 14'd2, 14'd5};
        drive_req(4'b1111, 4'b0000, a, '0);
        lat = 0;
        wait_resp(lat);
        snap = resp_rdata;
        check("bp_first_rdata", snap, exp_read(4'b1111, 4'b0000, a));
        req_valid = 1'b1; req_mask = 4'b1111; req_we = 4'b0000; req_addr = '0; req_wd = '0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check($sformatf("bp_hold%0d", c), {resp_valid, req_ready, resp_rdata}, {1'b1, 1'b0, snap});
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        check("bp_idle_after_handshake", {resp_valid, req_ready}, {1'b0, 1'b1});
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("bp_second_accepted", {127'b0, req_ready}, 128'd0);
        lat = 0;
        wait_resp(lat);
        take_resp(rd);
        check("bp_second_rdata", rd, exp_read(4'b1111, 4'b0000, '0));
        check("bp_second_latency", lat, exp_rounds(4'b1111, 4'b0000, '0) + 1);

        // Four bank-0 rounds: one lane's address presented per round, others hold.
        a = {14'd28, 14'd24, 14'd20, 14'd16};
        drive_req(4'b1111, 4'b0000, a, '0);
        for (int r = 0; r < 4; r++) begin
            check($sformatf("round%0d_addr", r), mem_addr[r], 14'd16 + 14'(4 * r));
            check($sformatf("round%0d_no_we", r), mem_we, 128'd0);
            if (r < 3) check($sformatf("round%0d_hold", r), {127'b0, mem_addr[r+1] == a[r+1]}, 128'd0);
            @(posedge clk); #1;
        end
        lat = 4;
        wait_resp(lat);
        take_resp(rd);
        check("bank0_rdata", rd, exp_read(4'b1111, 4'b0000, a));
        check("bank0_latency", lat, 5);

        // Reset during round 2 of a four-round write: only round 1 lands.
        d = {32'hDDDD_0003, 32'hDDDD_0002, 32'hDDDD_0001, 32'hDDDD_0000};
        drive_req(4'b1111, 4'b1111, a, d);
        @(posedge clk); #1;
        #2 reset = 1'b1;
        #1;
        check("midreset_ready_valid", {resp_valid, req_ready}, {1'b0, 1'b1});
        check("midreset_mem", {mem_we, mem_addr, mem_wd[1]}, 128'd0);
        check("midreset_mem_wd", mem_wd, 128'd0);
        check("midreset_rdata", resp_rdata, 128'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        ref_mem[16] = 32'hDDDD_0000;
        @(posedge clk); #1;
        do_req(4'b1111, 4'b0000, a, '0, rd, lat);
        check("midreset_sram", rd, exp_read(4'b1111, 4'b0000, a));

        // Random requests against the memory model.
        for (int t = 0; t < 40; t++) begin
            m = 4'($urandom);
            w = 4'($urandom);
            for (int i = 0; i < 4; i++) begin
                a[i] = 14'($urandom_range(0, 15));
                d[i] = $urandom;
            end
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 4; j++)
                    if (m[i] && m[j] && w[i] && !w[j] && a[i] == a[j]) w = 4'b0;
            do_req(m, w, a, d, rd, lat);
            check($sformatf("rand%0d_rdata", t), rd, exp_read(m, w, a));
            check($sformatf("rand%0d_latency", t), lat, (m == 4'b0) ? 1 : exp_rounds(m, w, a) + 1);
            apply_writes(m, w, a, d);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
